opb_master_single: RTL and testbench

Single-beat OPB bus master that turns a user command (address, data, byte enables, read/write) into one OPB transaction, then returns read data and a completion status. It is the initiator counterpart to the OPB slave register blocks (software registers, BRAM ports, gbe control), and lets fabric logic read or write those slaves directly on the shared OPB. It handles arbitration, retry, error acknowledge and timeout, and runs entirely in the OPB clock domain.

---
 rtl/opb_master_single.sv | 249 ++++++++++++++++++++++++
 tb/tb_opb_master_single.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_master_single.sv
// ---------------------------------------------------------------------------
// opb_master_single
//
// Single-beat OPB bus master. Accepts one user command (address, write data,
// byte enables, read/not-write), requests the bus, performs exactly one OPB
// transfer and returns read data plus a completion status. It handles
// arbitration, slave retry, error acknowledge and the no-acknowledge timeout.
// Everything runs in the OPB clock domain.
//
// Ports
//   OPB_Clk, OPB_Rst          clock, asynchronous active-high reset
//   cmd_valid / cmd_ready     command handshake
//   cmd_addr, cmd_data,       command payload (big-endian OPB bit order)
//   cmd_be, cmd_rnw
//   rsp_valid / rsp_ready     response handshake
//   rsp_data                  read data (0 for writes and failed transfers)
//   rsp_status                00 OK, 01 ERRACK, 10 TIMEOUT, 11 RETRY_EXHAUSTED
//   M_request, M_select,      master side of the OPB
//   M_ABus, M_BE, M_DBus,
//   M_RNW, M_seqAddr
//   OPB_MGrant, OPB_DBus,     arbiter grant and slave responses
//   OPB_xferAck, OPB_errAck,
//   OPB_retry, OPB_toutSup
//
// All outputs are registered. Their next values are derived from the next
// FSM state, so every output changes on the same edge as the state does.
// ---------------------------------------------------------------------------
module opb_master_single #(
  parameter int C_OPB_AWIDTH = 32,
  parameter int C_OPB_DWIDTH = 32,
  parameter int C_TIMEOUT    = 16,
  parameter int C_MAX_RETRY  = 4,
  parameter     C_FAMILY     = "virtex5"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [0:C_OPB_AWIDTH-1]     cmd_addr,
  input  logic [0:C_OPB_DWIDTH-1]     cmd_data,
  input  logic [0:C_OPB_DWIDTH/8-1]   cmd_be,
  input  logic                        cmd_rnw,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [0:C_OPB_DWIDTH-1]     rsp_data,
  output logic [1:0]                  rsp_status,
  output logic                        M_request,
  output logic                        M_select,
  output logic [0:C_OPB_AWIDTH-1]     M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1]   M_BE,
  output logic [0:C_OPB_DWIDTH-1]     M_DBus,
  output logic                        M_RNW,
  output logic                        M_seqAddr,
  input  logic                        OPB_MGrant,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_xferAck,
  input  logic                        OPB_errAck,
  input  logic                        OPB_retry,
  input  logic                        OPB_toutSup
);

  localparam int LP_WAIT_W = $clog2(C_TIMEOUT) + 1;
  localparam int LP_RTRY_W = $clog2(C_MAX_RETRY) + 1;
  localparam int LP_BE_W   = C_OPB_DWIDTH / 8;

  localparam logic [LP_WAIT_W-1:0] LP_WAIT_MAX = LP_WAIT_W'(C_TIMEOUT);
  localparam logic [LP_RTRY_W-1:0] LP_RTRY_MAX = LP_RTRY_W'(C_MAX_RETRY);

  localparam logic [1:0] LP_ST_OK      = 2'b00;
  localparam logic [1:0] LP_ST_ERRACK  = 2'b01;
  localparam logic [1:0] LP_ST_TIMEOUT = 2'b10;
  localparam logic [1:0] LP_ST_RETRY   = 2'b11;

  // The logic is family-independent; the parameter only keeps the block
  // drop-in compatible with the rest of the OPB core library.
  generate
    if (C_FAMILY == "") begin : g_family_unset
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_RESP
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nx;

  logic [LP_WAIT_W-1:0]      r_wait_cnt;
  logic [LP_WAIT_W-1:0]      w_wait_nx;
  logic [LP_RTRY_W-1:0]      r_retry_cnt;
  logic [LP_RTRY_W-1:0]      w_retry_nx;

  logic [0:C_OPB_DWIDTH-1]   w_rsp_data_nx;
  logic [1:0]                w_rsp_status_nx;
  logic                      w_latch;

  // Command latch (data only, no reset needed)
  logic [0:C_OPB_AWIDTH-1]   r_addr;
  logic [0:C_OPB_DWIDTH-1]   r_data;
  logic [0:LP_BE_W-1]        r_be;
  logic                      r_rnw;

  // Registered outputs
  logic                      r_cmd_ready;
  logic                      r_rsp_valid;
  logic [0:C_OPB_DWIDTH-1]   r_rsp_data;
  logic [1:0]                r_rsp_status;
  logic                      r_m_request;
  logic                      r_m_select;
  logic [0:C_OPB_AWIDTH-1]   r_m_abus;
  logic [0:LP_BE_W-1]        r_m_be;
  logic [0:C_OPB_DWIDTH-1]   r_m_dbus;
  logic                      r_m_rnw;

  // -------------------------------------------------------------------------
  // Next-state, counter and response computation
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nx      = r_state;
    w_wait_nx       = r_wait_cnt;
    w_retry_nx      = r_retry_cnt;
    w_rsp_data_nx   = r_rsp_data;
    w_rsp_status_nx = r_rsp_status;
    w_latch         = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_latch    = 1'b1;
          w_wait_nx  = '0;
          w_retry_nx = '0;
          w_state_nx = S_REQ;
        end
      end

      S_REQ: begin
        if (OPB_MGrant) begin
          w_state_nx = S_XFER;
        end
      end

      S_XFER: begin
        // errAck outranks xferAck; both outrank retry; retry outranks timeout
        if (OPB_errAck) begin
          w_rsp_status_nx = LP_ST_ERRACK;
          w_rsp_data_nx   = '0;
          w_state_nx      = S_RESP;
        end else if (OPB_xferAck) begin
          w_rsp_status_nx = LP_ST_OK;
          w_rsp_data_nx   = r_rnw ? OPB_DBus : '0;
          w_state_nx      = S_RESP;
        end else if (OPB_retry) begin
          w_retry_nx = r_retry_cnt + 1'b1;
          w_wait_nx  = '0;
          if (w_retry_nx == LP_RTRY_MAX) begin
            w_rsp_status_nx = LP_ST_RETRY;
            w_rsp_data_nx   = '0;
            w_state_nx      = S_RESP;
          end else begin
            w_state_nx = S_REQ;
          end
        end else begin
          // toutSup freezes the count; the counter never wraps
          if (!OPB_toutSup && (r_wait_cnt != LP_WAIT_MAX)) begin
            w_wait_nx = r_wait_cnt + 1'b1;
          end
          if (w_wait_nx == LP_WAIT_MAX) begin
            w_rsp_status_nx = LP_ST_TIMEOUT;
            w_rsp_data_nx   = '0;
            w_state_nx      = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_status_nx = LP_ST_OK;
          w_rsp_data_nx   = '0;
          w_state_nx      = S_IDLE;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, counters and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_retry_cnt  <= '0;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
      r_m_request  <= 1'b0;
      r_m_select   <= 1'b0;
      r_m_abus     <= '0;
      r_m_be       <= '0;
      r_m_dbus     <= '0;
      r_m_rnw      <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_wait_cnt   <= w_wait_nx;
      r_retry_cnt  <= w_retry_nx;
      r_cmd_ready  <= (w_state_nx == S_IDLE);
      r_rsp_valid  <= (w_state_nx == S_RESP);
      r_rsp_data   <= w_rsp_data_nx;
      r_rsp_status <= w_rsp_status_nx;
      r_m_request  <= (w_state_nx == S_REQ);
      r_m_select   <= (w_state_nx == S_XFER);
      // Bus drivers must be all-zero outside XFER for the OPB wired-OR
      r_m_abus     <= (w_state_nx == S_XFER) ? r_addr : '0;
      r_m_be       <= (w_state_nx == S_XFER) ? r_be   : '0;
      r_m_dbus     <= ((w_state_nx == S_XFER) && !r_rnw) ? r_data : '0;
      r_m_rnw      <= (w_state_nx == S_XFER) && r_rnw;
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (w_latch) begin
      r_addr <= cmd_addr;
      r_data <= cmd_data;
      r_be   <= cmd_be;
      r_rnw  <= cmd_rnw;
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_rsp_status;
  assign M_request  = r_m_request;
  assign M_select   = r_m_select;
  assign M_ABus     = r_m_abus;
  assign M_BE       = r_m_be;
  assign M_DBus     = r_m_dbus;
  assign M_RNW      = r_m_rnw;
  assign M_seqAddr  = 1'b0;

endmodule

// File: tb/tb_opb_master_single.sv
// ---------------------------------------------------------------------------
// tb_opb_master_single
//
// Self-checking bench for opb_master_single. Each scenario describes the bus
// environment at transaction level (grant delay, and per bus attempt the
// number of select cycles before the slave answers and what it answers).
// A reference model turns that description into the expected status, read
// data, latency and request/select cycle counts; a reactive arbiter/slave
// process drives the DUT from the same description.
// ---------------------------------------------------------------------------
module tb_opb_master_single;

  localparam int T      = 16;
  localparam int MAXR   = 4;
  localparam int BUDGET = 400;

  localparam int R_NONE  = 0;
  localparam int R_ACK   = 1;
  localparam int R_ERR   = 2;
  localparam int R_BOTH  = 3;
  localparam int R_RETRY = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  cmd_be = '0;
  logic        cmd_rnw = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        M_request, M_select, M_RNW, M_seqAddr;
  logic [31:0] M_ABus, M_DBus;
  logic [3:0]  M_BE;
  logic        OPB_MGrant = 1'b0;
  logic [31:0] OPB_DBus = '0;
  logic        OPB_xferAck = 1'b0;
  logic        OPB_errAck = 1'b0;
  logic        OPB_retry = 1'b0;
  logic        OPB_toutSup = 1'b0;

  always #5 clk = ~clk;

  opb_master_single #(
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_TIMEOUT   (T),
    .C_MAX_RETRY (MAXR),
    .C_FAMILY    ("virtex5")
  ) dut (
    .OPB_Clk    (clk),
    .OPB_Rst    (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_be     (cmd_be),
    .cmd_rnw    (cmd_rnw),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_status (rsp_status),
    .M_request  (M_request),
    .M_select   (M_select),
    .M_ABus     (M_ABus),
    .M_BE       (M_BE),
    .M_DBus     (M_DBus),
    .M_RNW      (M_RNW),
    .M_seqAddr  (M_seqAddr),
    .OPB_MGrant (OPB_MGrant),
    .OPB_DBus   (OPB_DBus),
    .OPB_xferAck(OPB_xferAck),
    .OPB_errAck (OPB_errAck),
    .OPB_retry  (OPB_retry),
    .OPB_toutSup(OPB_toutSup)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scenario description
  logic        sc_rnw;
  logic [31:0] sc_addr, sc_data, sc_rd;
  logic [3:0]  sc_be;
  int          sc_gd, sc_hold, sc_n;
  bit          sc_tsup;
  int          sc_w[4];
  int          sc_r[4];

  // Model expectations
  logic [1:0]  ex_status;
  logic [31:0] ex_data;
  int          ex_lat, ex_req, ex_sel;

  // Observations
  bit          ob_done, ob_accept, ob_post;
  logic [1:0]  ob_status;
  logic [31:0] ob_data;
  int          ob_lat, ob_req, ob_sel, ob_busviol, ob_holdviol;

  task automatic set_sc(input logic rnw, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input logic [3:0] be,
                        input int gd, input bit tsup, input int hold);
    sc_rnw = rnw; sc_addr = a; sc_data = d; sc_rd = rd; sc_be = be;
    sc_gd = gd; sc_tsup = tsup; sc_hold = hold; sc_n = 0;
  endtask

  task automatic add_att(input int w, input int r);
    sc_w[sc_n] = w;
    sc_r[sc_n] = r;
    sc_n++;
  endtask

  // Transaction-level reference: each bus attempt costs (grant delay + 1)
  // request cycles and then either the select cycles up to the answer or
  // T select cycles when the slave stays silent without toutSup.
  function automatic void model();
    int retries;
    bit done;
    ex_lat = 0; ex_req = 0; ex_sel = 0; ex_status = 2'b00; ex_data = '0;
    retries = 0; done = 0;
    for (int i = 0; i < sc_n && !done; i++) begin
      ex_req++;
      ex_lat += sc_gd + 1;
      if (!sc_tsup && (sc_r[i] == R_NONE || sc_w[i] >= T)) begin
        ex_sel += T; ex_lat += T; ex_status = 2'b10; done = 1;
      end else begin
        ex_sel += sc_w[i] + 1;
        ex_lat += sc_w[i] + 1;
        if (sc_r[i] == R_ACK) begin
          ex_status = 2'b00; ex_data = sc_rnw ? sc_rd : 32'h0; done = 1;
        end else if (sc_r[i] == R_ERR || sc_r[i] == R_BOTH) begin
          ex_status = 2'b01; done = 1;
        end else begin
          retries++;
          if (retries == MAXR) begin
            ex_status = 2'b11; done = 1;
          end
        end
      end
    end
  endfunction

  task automatic clear_inputs();
    OPB_MGrant = 0; OPB_xferAck = 0; OPB_errAck = 0; OPB_retry = 0;
    OPB_toutSup = 0; OPB_DBus = '0; cmd_valid = 0; rsp_ready = 0;
  endtask

  // Issues the scenario's command, plays arbiter and slave, records what
  // the DUT did. Called and left at a falling clock edge.
  task automatic do_txn();
    int e, req_k, sel_k, att, wt;
    bit prev_req;
    logic [31:0] hd;
    logic [1:0]  hs;
    ob_done = 0; ob_post = 0; ob_req = 0; ob_sel = 0; ob_busviol = 0;
    ob_holdviol = 0; ob_lat = -1; ob_status = 'x; ob_data = 'x;
    @(negedge clk);
    wt = 0;
    while (cmd_ready !== 1'b1 && wt < 5) begin
      @(negedge clk); wt++;
    end
    ob_accept = (cmd_ready === 1'b1);
    cmd_valid = 1; cmd_addr = sc_addr; cmd_data = sc_data; cmd_be = sc_be; cmd_rnw = sc_rnw;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0; cmd_addr = $urandom; cmd_data = $urandom;
    e = 0; req_k = 0; sel_k = 0; att = 0; prev_req = 0;
    while (1) begin
      if (rsp_valid === 1'b1) begin
        ob_done = 1;
        break;
      end
      if (e >= BUDGET) break;
      if (M_request && !prev_req) ob_req++;
      prev_req = M_request;
      if (M_seqAddr !== 1'b0 || cmd_ready !== 1'b0) ob_busviol++;
      if (M_select === 1'b1) begin
        ob_sel++;
        if (M_ABus !== sc_addr || M_BE !== sc_be || M_RNW !== sc_rnw || M_request !== 1'b0 ||
            M_DBus !== (sc_rnw ? 32'h0 : sc_data)) ob_busviol++;
      end else if (M_ABus !== 0 || M_BE !== 0 || M_DBus !== 0 || M_RNW !== 0) begin
        ob_busviol++;
      end
      OPB_MGrant = 0; OPB_xferAck = 0; OPB_errAck = 0; OPB_retry = 0;
      OPB_toutSup = 0; OPB_DBus = $urandom;
      if (M_request === 1'b1) begin
        if (req_k == sc_gd) OPB_MGrant = 1;
        req_k++;
      end else begin
        req_k = 0;
      end
      if (M_select === 1'b1) begin
        OPB_toutSup = sc_tsup;
        if (att < sc_n && sel_k == sc_w[att]) begin
          case (sc_r[att])
            R_ACK:   begin OPB_xferAck = 1; OPB_DBus = sc_rd; end
            R_ERR:   begin OPB_errAck = 1; OPB_DBus = sc_rd; end
            R_BOTH:  begin OPB_xferAck = 1; OPB_errAck = 1; OPB_DBus = sc_rd; end
            R_RETRY: begin OPB_retry = 1; att++; end
            default: ;
          endcase
        end
        sel_k++;
      end else begin
        sel_k = 0;
      end
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    clear_inputs();
    if (!ob_done) begin
      rst = 1; #2; rst = 0;
      @(negedge clk);
      return;
    end
    ob_lat = e; ob_status = rsp_status; ob_data = rsp_data;
    hd = rsp_data; hs = rsp_status;
    // Hold the response while throwing stray grants/acks/commands at the DUT
    for (int i = 0; i < sc_hold; i++) begin
      OPB_MGrant = $urandom; OPB_xferAck = $urandom; OPB_errAck = $urandom;
      OPB_retry = $urandom; OPB_DBus = $urandom; cmd_valid = $urandom;
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== hd || rsp_status !== hs || cmd_ready !== 1'b0 ||
          M_request !== 1'b0 || M_select !== 1'b0 || M_ABus !== 0 || M_DBus !== 0 ||
          M_BE !== 0 || M_RNW !== 0) ob_holdviol++;
    end
    clear_inputs();
    rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 0;
    ob_post = (rsp_valid === 1'b0) && (cmd_ready === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    #12;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_status, M_request, M_select, M_ABus, M_BE,
         M_DBus, M_RNW, M_seqAddr} !== '0)
      $display("FAIL reset_outputs: got cmd_ready=%b rsp_valid=%b M_request=%b M_select=%b M_ABus=%h expected all 0",
               cmd_ready, rsp_valid, M_request, M_select, M_ABus);
    else n_pass++;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || M_request !== 1'b0)
      $display("FAIL reset_release: got cmd_ready=%b rsp_valid=%b M_request=%b expected 1 0 0",
               cmd_ready, rsp_valid, M_request);
    else n_pass++;
  endtask

  task automatic test_write_basic();
    set_sc(1'b0, 32'h0100_0300, 32'hDEAD_BEEF, 32'hAAAA_5555, 4'hF, 0, 0, 0);
    add_att(0, R_ACK);
    do_txn();
    n_checks++;
    if (!ob_done || ob_status !== 2'b00 || ob_data !== 32'h0)
      $display("FAIL write_basic_rsp: done=%0d status=%b data=%h expected 1 00 00000000", ob_done, ob_status, ob_data);
    else n_pass++;
    n_checks++;
    if (ob_lat !== 2 || ob_sel !== 1 || ob_req !== 1)
      $display("FAIL write_basic_timing: lat=%0d sel=%0d req=%0d expected 2 1 1", ob_lat, ob_sel, ob_req);
    else n_pass++;
    n_checks++;
    if (!ob_accept || ob_busviol !== 0 || !ob_post)
      $display("FAIL write_basic_bus: accept=%0d busviol=%0d post=%0d expected 1 0 1", ob_accept, ob_busviol, ob_post);
    else n_pass++;
  endtask

  task automatic test_read_delayed();
    set_sc(1'b1, 32'h0100_0300, 32'hFFFF_FFFF, 32'h1234_5678, 4'hF, 3, 0, 0);
    add_att(1, R_ACK);
    model();
    do_txn();
    n_checks++;
    if (!ob_done || ob_status !== 2'b00 || ob_data !== 32'h1234_5678)
      $display("FAIL read_delayed_rsp: status=%b data=%h expected 00 12345678", ob_status, ob_data);
    else n_pass++;
    n_checks++;
    if (ob_lat !== ex_lat || ob_sel !== 2 || ob_busviol !== 0)
      $display("FAIL read_delayed_timing: lat=%0d sel=%0d busviol=%0d expected %0d 2 0", ob_lat, ob_sel, ob_busviol, ex_lat);
    else n_pass++;
  endtask

  task automatic test_retry();
    for (int k = 3; k <= 4; k++) begin
      set_sc(1'b1, $urandom, $urandom, 32'hCAFE_0000 | k, 4'b0011, k - 3, 0, 1);
      for (int i = 0; i < k; i++) add_att(i, R_RETRY);
      if (k < MAXR) add_att(0, R_ACK);
      model();
      do_txn();
      n_checks++;
      if (!ob_done || ob_status !== ex_status || ob_data !== ex_data)
        $display("FAIL retry%0d_rsp: status=%b data=%h expected %b %h", k, ob_status, ob_data, ex_status, ex_data);
      else n_pass++;
      n_checks++;
      if (ob_req !== ex_req || ob_sel !== ex_sel || ob_lat !== ex_lat || ob_busviol !== 0)
        $display("FAIL retry%0d_timing: req=%0d sel=%0d lat=%0d busviol=%0d expected %0d %0d %0d 0",
                 k, ob_req, ob_sel, ob_lat, ob_busviol, ex_req, ex_sel, ex_lat);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 4; k++) begin
      set_sc(k[0], $urandom, $urandom, $urandom, 4'b1000, 1, (k == 3), 0);
      case (k)
        0: add_att(0, R_NONE);
        1: add_att(T - 1, R_ACK);
        2: add_att(T, R_ACK);
        default: add_att(40, R_ACK);
      endcase
      model();
      do_txn();
      n_checks++;
      if (!ob_done || ob_status !== ex_status || ob_data !== ex_data)
        $display("FAIL timeout%0d_rsp: status=%b data=%h expected %b %h", k, ob_status, ob_data, ex_status, ex_data);
      else n_pass++;
      n_checks++;
      if (ob_sel !== ex_sel || ob_lat !== ex_lat || ob_busviol !== 0)
        $display("FAIL timeout%0d_timing: sel=%0d lat=%0d busviol=%0d expected %0d %0d 0",
                 k, ob_sel, ob_lat, ob_busviol, ex_sel, ex_lat);
      else n_pass++;
    end
  endtask

  task automatic test_errack_hold();
    for (int k = 0; k < 2; k++) begin
      set_sc(1'b1, $urandom, $urandom, 32'h5A5A_A5A5, 4'hF, 0, 0, 5);
      add_att(k + 1, (k == 0) ? R_BOTH : R_ERR);
      model();
      do_txn();
      n_checks++;
      if (!ob_done || ob_status !== 2'b01 || ob_data !== 32'h0)
        $display("FAIL errack%0d_rsp: status=%b data=%h expected 01 00000000", k, ob_status, ob_data);
      else n_pass++;
      n_checks++;
      if (ob_holdviol !== 0 || !ob_post || ob_lat !== ex_lat)
        $display("FAIL errack%0d_hold: holdviol=%0d post=%0d lat=%0d expected 0 1 %0d", k, ob_holdviol, ob_post, ob_lat, ex_lat);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int  r, w, bad;
    bit  term;
    bad = 0;
    for (int t = 0; t < 30; t++) begin
      set_sc($urandom_range(0, 1), $urandom, $urandom, $urandom, 4'($urandom),
             $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      term = 0;
      for (int i = 0; i < MAXR && !term; i++) begin
        r = $urandom_range(0, 4);
        if (sc_tsup && r == R_NONE) r = R_ACK;
        w = ($urandom_range(0, 4) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 4);
        add_att(w, r);
        term = (r != R_RETRY) || (!sc_tsup && w >= T);
      end
      model();
      do_txn();
      n_checks++;
      if (!ob_done || ob_status !== ex_status || ob_data !== ex_data) begin
        $display("FAIL random%0d_rsp: status=%b data=%h expected %b %h", t, ob_status, ob_data, ex_status, ex_data);
        bad++;
      end else n_pass++;
      n_checks++;
      if (ob_lat !== ex_lat || ob_req !== ex_req || ob_sel !== ex_sel)
        $display("FAIL random%0d_timing: lat=%0d req=%0d sel=%0d expected %0d %0d %0d",
                 t, ob_lat, ob_req, ob_sel, ex_lat, ex_req, ex_sel);
      else n_pass++;
      n_checks++;
      if (ob_busviol !== 0 || ob_holdviol !== 0 || !ob_post || !ob_accept)
        $display("FAIL random%0d_protocol: busviol=%0d holdviol=%0d post=%0d accept=%0d expected 0 0 1 1",
                 t, ob_busviol, ob_holdviol, ob_post, ob_accept);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midxfer();
    int stray;
    @(negedge clk);
    cmd_valid = 1; cmd_addr = 32'h0200_0010; cmd_data = 32'h0BAD_F00D; cmd_be = 4'hF; cmd_rnw = 0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    OPB_MGrant = 1;
    @(posedge clk);
    @(negedge clk);
    OPB_MGrant = 0;
    n_checks++;
    if (M_select !== 1'b1 || M_DBus !== 32'h0BAD_F00D)
      $display("FAIL midxfer_select: M_select=%b M_DBus=%h expected 1 0badf00d", M_select, M_DBus);
    else n_pass++;
    #2 rst = 1;
    #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_data, rsp_status, M_request, M_select, M_ABus, M_BE,
         M_DBus, M_RNW, M_seqAddr} !== '0)
      $display("FAIL midxfer_reset_outputs: M_select=%b M_ABus=%h M_DBus=%h cmd_ready=%b expected all 0",
               M_select, M_ABus, M_DBus, cmd_ready);
    else n_pass++;
    OPB_xferAck = 1;
    @(negedge clk);
    rst = 0;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      OPB_xferAck = 0;
      if (rsp_valid !== 1'b0 || M_request !== 1'b0 || M_select !== 1'b0) stray++;
    end
    n_checks++;
    if (stray !== 0 || cmd_ready !== 1'b1)
      $display("FAIL midxfer_no_rsp: stray=%0d cmd_ready=%b expected 0 1", stray, cmd_ready);
    else n_pass++;
    set_sc(1'b1, 32'h0200_0010, 32'h0, 32'h7654_3210, 4'hF, 1, 0, 0);
    add_att(2, R_ACK);
    model();
    do_txn();
    n_checks++;
    if (!ob_done || ob_status !== 2'b00 || ob_data !== 32'h7654_3210 || ob_lat !== ex_lat)
      $display("FAIL midxfer_next_cmd: status=%b data=%h lat=%0d expected 00 76543210 %0d",
               ob_status, ob_data, ob_lat, ex_lat);
    else n_pass++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_basic();
    test_read_delayed();
    test_retry();
    test_timeout();
    test_errack_hold();
    test_random();
    test_reset_midxfer();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
